bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_if.sv | 24 ++
 rtl/bin2bcd_seq.sv | 82 ++++++++
 tb/tb_bin2bcd_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for the iterative binary-to-BCD converter.
// start/bin are sampled together on a rising edge only while busy is low; done pulses
// for one cycle when bcd has just been updated, and bcd holds that value until the next done.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  shift_dbg;  // FSM state: 1 = SHIFT, 0 = IDLE

  modport master (
    output start, bin,
    input  bcd, busy, done, shift_dbg
  );

  modport slave (
    input  start, bin,
    output bcd, busy, done, shift_dbg
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Double-dabble converter: one add-3/shift step per clock, WIDTH steps per conversion.
// The result register only updates on completion, so bcd never shows partial digits.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  bin2bcd_seq_if.slave bus
);
  localparam int SRW = 4 * DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state, state_n;
  logic [SRW-1:0]        sr, sr_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [4*DIGITS-1:0]   bcd_q, bcd_n;
  logic                  done_q, done_n;
  logic [SRW-1:0]        adj;
  logic [SRW-1:0]        shifted;

  // Every BCD nibble (including the top one) gets +3 when >= 5, before the shift.
  always_comb begin
    adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[WIDTH+4*i +: 4] >= 4'd5)
        adj[WIDTH+4*i +: 4] = adj[WIDTH+4*i +: 4] + 4'd3;
    end
    shifted = {adj[SRW-2:0], 1'b0};
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    bcd_n   = bcd_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sr_n             = '0;
          sr_n[WIDTH-1:0]  = bus.bin;
          cnt_n            = '0;
          state_n          = SHIFT;
        end
      end
      SHIFT: begin
        sr_n  = shifted;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          bcd_n   = shifted[SRW-1 -: 4*DIGITS];
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      bcd_q  <= bcd_n;
      done_q <= done_n;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state == SHIFT);
  assign bus.shift_dbg = (state == SHIFT);
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed steps plus random and exhaustive values, checked
// against a divide-by-ten digit model; a second instance covers WIDTH=12, DIGITS=4.
module tb_bin2bcd_seq;
  logic clk;
  logic reset;

  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) b   ();
  bin2bcd_seq_if #(.WIDTH(12), .DIGITS(4)) b12 ();

  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut   (.clk(clk), .reset(reset), .bus(b));
  bin2bcd_seq #(.WIDTH(12), .DIGITS(4)) dut12 (.clk(clk), .reset(reset), .bus(b12));

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [11:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (reset === 1'b1 && b.start === 1'b1 && b.busy === 1'b0)
      exp_q.push_back(12'(to_bcd(int'(b.bin))));
  end

  always @(negedge clk) begin
    if (b.done === 1'b1) begin
      logic nib_ok;
      done_cnt++;
      check("done_single_cycle", 32'(prev_done), 32'd0);
      nib_ok = 1'b1;
      for (int i = 0; i < 3; i++)
        if (b.bcd[4*i +: 4] > 4'd9) nib_ok = 1'b0;
      check("nibble_range", 32'(nib_ok), 32'd1);
      if (exp_q.size() == 0)
        check("unexpected_done", 32'(b.done), 32'd0);
      else
        check("sb_bcd", 32'(b.bcd), 32'(exp_q.pop_front()));
    end
    prev_done = b.done;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input bit scramble, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble) b.bin = 8'($urandom);
    end while (b.done !== 1'b1 && n < 40);
    check("done_seen", 32'(b.done), 32'd1);
  endtask

  task automatic convert(input logic [7:0] v, input string tag);
    int n;
    @(negedge clk);
    b.start = 1'b1;
    b.bin   = v;
    @(negedge clk);
    b.start = 1'b0;
    b.bin   = 8'($urandom);
    check({tag, "_busy_on"}, 32'(b.busy), 32'd1);
    wait_done(1'b0, n);
    check({tag, "_latency"}, 32'(n + 1), 32'd9);
    check({tag, "_busy_off"}, 32'(b.busy), 32'd0);
    check({tag, "_bcd"}, 32'(b.bcd), to_bcd(int'(v)) & 32'hFFF);
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(b.done), 32'd0);
  endtask

  task automatic convert12(input logic [11:0] v, input string tag);
    int n;
    @(negedge clk);
    b12.start = 1'b1;
    b12.bin   = v;
    @(negedge clk);
    b12.start = 1'b0;
    b12.bin   = 12'($urandom);
    n = 1;
    while (b12.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(b12.done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd13);
    check({tag, "_bcd"}, 32'(b12.bcd), to_bcd(int'(v)) & 32'hFFFF);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int mark;
    reset     = 1'b0;
    b.start   = 1'b0;
    b.bin     = '0;
    b12.start = 1'b0;
    b12.bin   = '0;
    repeat (3) @(negedge clk);
    check("rst_bcd",   32'(b.bcd),       32'd0);
    check("rst_busy",  32'(b.busy),      32'd0);
    check("rst_done",  32'(b.done),      32'd0);
    check("rst_state", 32'(b.shift_dbg), 32'd0);
    reset = 1'b1;

    convert(8'hFF, "ff");
    convert(8'h00, "zero");
    convert(8'h63, "x63");
    convert(8'h64, "x64");

    // start held high; bin changes on the done cycle and randomly while busy
    @(negedge clk);
    b.start = 1'b1;
    b.bin   = 8'h0A;
    wait_done(1'b0, n);
    check("held_a_bcd", 32'(b.bcd), 32'h010);
    b.bin = 8'h80;
    wait_done(1'b1, n);
    b.start = 1'b0;
    check("held_spacing", 32'(n), 32'd9);
    check("held_b_bcd", 32'(b.bcd), 32'h128);

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    b.start = 1'b1;
    b.bin   = 8'hC8;
    @(negedge clk);
    b.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_bcd",  32'(b.bcd),  32'd0);
    check("abort_busy", 32'(b.busy), 32'd0);
    check("abort_done", 32'(b.done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    mark = done_cnt;
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - mark), 32'd0);
    convert(8'hC8, "c8");

    for (int i = 0; i < 10; i++)
      convert(8'($urandom_range(0, 255)), "rand");

    // exhaustive sweep, back-to-back
    mark = done_cnt;
    @(negedge clk);
    b.start = 1'b1;
    b.bin   = 8'd0;
    for (int v = 1; v < 256; v++) begin
      wait_done(1'b0, n);
      b.bin = 8'(v);
    end
    wait_done(1'b0, n);
    b.start = 1'b0;
    @(negedge clk);
    check("sweep_count", 32'(done_cnt - mark), 32'd256);
    check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

    convert12(12'hFFF, "w12_fff");
    for (int i = 0; i < 4; i++)
      convert12(12'($urandom_range(0, 4095)), "w12_rand");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
